lc3_fetch_ctrl: RTL and testbench
=================================

# lc3_fetch_ctrl

Instruction-fetch sequencer for the LC3 microcontroller. It owns the program counter and drives the instruction-memory port: it issues read requests, waits for `complete_instr`, and captures `Instr_dout`. Each fetched word goes to the decode stage over a valid/ready handshake. It sits between the instruction_memory bus (as initiator) and the decode/control logic, and it handles branch redirects and fetch enable/stall.

## Interface
Parameters:
- `RESET_PC`, 16'h3000, PC value loaded at reset.
- `TIMEOUT`, 15, maximum WAIT cycles before abort (used only with `FETCH_TIMEOUT_EN`); legal range 1..255.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable_fetch` in 1: permits new fetch requests.
- `br_taken` in 1: one-cycle redirect strobe.
- `br_target` in 16: redirect address, valid with `br_taken`.
- `instrmem_rd` out 1: read request pulse to instruction memory.
- `PC` out 16: fetch address to instruction memory.
- `I_macc` out 1: instruction-memory access in progress.
- `Instr_dout` in 16: instruction word from memory.
- `complete_instr` in 1: memory read complete; `Instr_dout` is valid in the same cycle.
- `instr_valid` out 1: fetched instruction available to decode.
- `instr_out` out 16: fetched instruction word.
- `instr_pc` out 16: address of `instr_out`.
- `instr_ready` in 1: decode accepts `instr_out`.
- `fetch_err` out 1: sticky fetch timeout flag.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- **Reset:**
  - State goes to IDLE.
  - `PC` = `RESET_PC`.
  - `instrmem_rd`, `I_macc`, `instr_valid` and `fetch_err` = 0.
  - `instr_out` and `instr_pc` = 16'h0000.
  - Reset takes effect mid-access; any in-flight read is abandoned and a late `complete_instr` is ignored.
- **IDLE:**
  - `enable_fetch`=1 and `fetch_err`=0 → REQ.
- **REQ:**
  - `instrmem_rd`=1 and `I_macc`=1 for exactly one cycle; `PC` stable.
  - Always → WAIT.
  - `complete_instr` is ignored in REQ; memory latency is at least 1 cycle.
- **WAIT:**
  - `I_macc`=1.
  - On `complete_instr`=1:
    - `instr_out` ← `Instr_dout`, `instr_pc` ← `PC`.
    - `instr_valid` ← 1.
    - `PC` ← `PC`+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
    - `I_macc` ← 0; → HOLD.
- **HOLD:**
  - `instr_valid`=1; `instr_out` and `instr_pc` stay stable until accepted.
  - On `instr_valid`&`instr_ready`: `instr_valid` ← 0; → REQ if `enable_fetch`, else IDLE.
- **Redirect (`br_taken`=1):**
  - IDLE: `PC` ← `br_target`.
  - HOLD: `PC` ← `br_target`; held instruction squashed (`instr_valid` ← 0) even if `instr_ready`=1; → REQ if `enable_fetch`, else IDLE.
  - REQ/WAIT: target latched into a pending register; a later redirect before completion overwrites it (latest wins).
    - On `complete_instr`: data discarded, no `instr_valid`, `PC` ← pending target, pending cleared.
    - Then → REQ if `enable_fetch`, else IDLE.
- **`enable_fetch` deasserted during REQ/WAIT:** the current access completes and is delivered normally; no further request is issued.
- `complete_instr` outside WAIT is ignored.

## Timing
- Request to data: `instr_valid` rises on the cycle after `complete_instr` is sampled.
- Minimum cycles per instruction is 3 (REQ, one WAIT, HOLD with `instr_ready`=1).
- `instrmem_rd` never asserts on consecutive cycles.
- `PC` changes only:
  - on the edge leaving WAIT,
  - on a redirect in IDLE/HOLD,
  - at reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `LC3_FETCH_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `complete_instr`.
  - When the count reaches `TIMEOUT`:
    - `I_macc` ← 0 and `fetch_err` ← 1.
    - → IDLE; `PC` unchanged; any pending redirect is dropped.
  - `fetch_err` stays 1 until reset and blocks new requests.
- **Not defined:** no counter; WAIT lasts indefinitely; `fetch_err` is tied to 0.

## Test plan
- **Reset and first fetch:** release reset with `enable_fetch`=1. Memory returns 16'h1234 after 2 cycles. Required:
  - `instrmem_rd` pulses with `PC`=16'h3000.
  - `instr_out`=16'h1234, `instr_pc`=16'h3000.
  - `PC` then 16'h3001.
- **Back-pressure:** hold `instr_ready`=0 for 5 cycles. Required: `instr_valid`, `instr_out` and `instr_pc` stable; no new `instrmem_rd` until acceptance.
- **Redirect during WAIT:** `br_taken` with 16'h4000, then `br_taken` with 16'h5000 before `complete_instr`. Required:
  - No `instr_valid` for the in-flight word.
  - Next request has `PC`=16'h5000.
- **Redirect in HOLD with `instr_ready`=1 in the same cycle:** required: instruction squashed; next `PC` is the target.
- **Wrap:** `br_target`=16'hFFFF, one fetch completes. Required: `instr_pc`=16'hFFFF; next request `PC`=16'h0000.
- **Timeout (`LC3_FETCH_TIMEOUT_EN`, `TIMEOUT`=4):** never assert `complete_instr`. Required:
  - `fetch_err`=1 after 4 WAIT cycles; `I_macc`=0.
  - No further `instrmem_rd` until reset.

Source files
------------

// File: rtl/lc3_fetch_ctrl.sv
// lc3_fetch_ctrl
// Instruction-fetch sequencer for the LC3 microcontroller. Owns the program
// counter, issues single-cycle read requests to instruction memory, waits for
// the read to complete, then holds the fetched word for decode behind a
// valid/ready handshake. Branch redirects are applied immediately when no
// access is outstanding. Otherwise they are parked until the in-flight read
// returns, and that read's data is discarded.
//
// Build option: define LC3_FETCH_TIMEOUT_EN to add an 8-bit WAIT watchdog.
// When it expires it raises the sticky fetch_err flag. Without the macro,
// WAIT is unbounded and fetch_err is constant 0.
//
// Ports
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   enable_fetch      : permits new read requests
//   br_taken/br_target: one-cycle redirect strobe and target address
//   instrmem_rd, PC   : read request pulse and fetch address to memory
//   I_macc            : memory access in progress (REQ or WAIT)
//   Instr_dout        : read data, valid while complete_instr is high
//   complete_instr    : read completion from memory
//   instr_valid/ready : handshake with decode
//   instr_out/pc      : fetched word and its address
//   fetch_err         : sticky fetch timeout flag
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access outstanding; waiting for enable_fetch
// REQ    | read request issued this cycle (instrmem_rd high)
// WAIT   | waiting for complete_instr
// HOLD   | fetched word presented to decode until accepted or squashed

module lc3_fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h3000,
   parameter int          TIMEOUT  = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_fetch,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic        instrmem_rd,
   output logic [15:0] PC,
   output logic        I_macc,
   input  logic [15:0] Instr_dout,
   input  logic        complete_instr,
   output logic        instr_valid,
   output logic [15:0] instr_out,
   output logic [15:0] instr_pc,
   input  logic        instr_ready,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   state_t      resume;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] ipc_q, ipc_d;
   logic [15:0] pend_pc_q, pend_pc_d;
   logic        pend_vld_q, pend_vld_d;
   logic        rd_q, rd_d;
   logic        macc_q, macc_d;
   logic        valid_q, valid_d;
   logic [15:0] redir_pc;

`ifdef LC3_FETCH_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d, cnt_inc;
   logic        err_q, err_d;
   assign cnt_inc   = cnt_q + 8'd1;
   assign fetch_err = err_q;
`else
   // Constant 0; TIMEOUT has no effect without the watchdog.
   assign fetch_err = 1'b0 & (TIMEOUT == 0);
`endif

   assign resume = enable_fetch ? S_REQ : S_IDLE;

   // A redirect arriving in the same cycle as completion is the latest one,
   // so it takes precedence over the parked target.
   assign redir_pc = br_taken ? br_target : pend_pc_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      ipc_d      = ipc_q;
      pend_pc_d  = pend_pc_q;
      pend_vld_d = pend_vld_q;
`ifdef LC3_FETCH_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (br_taken) pc_d = br_target;
            if (enable_fetch && !fetch_err) state_d = S_REQ;
         end
         S_REQ: begin
            if (br_taken) begin
               pend_vld_d = 1'b1;
               pend_pc_d  = br_target;
            end
`ifdef LC3_FETCH_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (br_taken) begin
               pend_vld_d = 1'b1;
               pend_pc_d  = br_target;
            end
            if (complete_instr) begin
               if (br_taken || pend_vld_q) begin
                  pc_d       = redir_pc;
                  pend_vld_d = 1'b0;
                  state_d    = resume;
               end else begin
                  instr_d = Instr_dout;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + 16'd1;
                  state_d = S_HOLD;
               end
            end
`ifdef LC3_FETCH_TIMEOUT_EN
            else if (cnt_inc == 8'(TIMEOUT)) begin
               err_d      = 1'b1;
               pend_vld_d = 1'b0;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
`endif
         end
         S_HOLD: begin
            if (br_taken) begin
               pc_d    = br_target;
               state_d = resume;
            end else if (instr_ready) begin
               state_d = resume;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered copies of the next-state decode.
      rd_d    = (state_d == S_REQ);
      macc_d  = (state_d == S_REQ) || (state_d == S_WAIT);
      valid_d = (state_d == S_HOLD);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= 16'h0000;
         ipc_q      <= 16'h0000;
         pend_pc_q  <= 16'h0000;
         pend_vld_q <= 1'b0;
         rd_q       <= 1'b0;
         macc_q     <= 1'b0;
         valid_q    <= 1'b0;
`ifdef LC3_FETCH_TIMEOUT_EN
         cnt_q      <= 8'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         ipc_q      <= ipc_d;
         pend_pc_q  <= pend_pc_d;
         pend_vld_q <= pend_vld_d;
         rd_q       <= rd_d;
         macc_q     <= macc_d;
         valid_q    <= valid_d;
`ifdef LC3_FETCH_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign instrmem_rd = rd_q;
   assign PC          = pc_q;
   assign I_macc      = macc_q;
   assign instr_valid = valid_q;
   assign instr_out   = instr_q;
   assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
module tb_lc3_fetch_ctrl;
   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable_fetch = 1'b0;
   logic        br_taken = 1'b0;
   logic [15:0] br_target = 16'h0000;
   logic [15:0] Instr_dout = 16'h0000;
   logic        complete_instr = 1'b0;
   logic        instr_ready = 1'b0;
   logic        instrmem_rd, I_macc, instr_valid, fetch_err;
   logic [15:0] PC, instr_out, instr_pc;

   int n_total = 0;
   int n_fail  = 0;
   int lat_left = 0;

   lc3_fetch_ctrl #(.RESET_PC(16'h3000), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
      .br_taken(br_taken), .br_target(br_target),
      .instrmem_rd(instrmem_rd), .PC(PC), .I_macc(I_macc),
      .Instr_dout(Instr_dout), .complete_instr(complete_instr),
      .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .fetch_err(fetch_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: m_acc 0 = no access, 1 = request cycle, 2 = awaiting data.
   int          m_acc, m_wait_n;
   bit          m_hold, m_redir, m_err;
   logic [15:0] m_pc, m_word, m_wpc, m_redir_pc;

   task automatic model_reset();
      m_acc = 0; m_wait_n = 0; m_hold = 0; m_redir = 0; m_err = 0;
      m_pc = 16'h3000; m_word = 16'h0000; m_wpc = 16'h0000; m_redir_pc = 16'h0000;
   endtask

   task automatic model_step();
      if (m_hold) begin
         if (br_taken) begin
            m_pc = br_target; m_hold = 0; m_acc = enable_fetch ? 1 : 0;
         end else if (instr_ready) begin
            m_hold = 0; m_acc = enable_fetch ? 1 : 0;
         end
      end else if (m_acc == 1) begin
         if (br_taken) begin m_redir = 1; m_redir_pc = br_target; end
         m_acc = 2; m_wait_n = 0;
      end else if (m_acc == 2) begin
         if (br_taken) begin m_redir = 1; m_redir_pc = br_target; end
         if (complete_instr) begin
            m_acc = 0;
            if (m_redir) begin
               m_pc = m_redir_pc; m_redir = 0; m_acc = enable_fetch ? 1 : 0;
            end else begin
               m_word = Instr_dout; m_wpc = m_pc; m_pc = m_pc + 16'd1; m_hold = 1;
            end
         end else begin
            m_wait_n++;
`ifdef LC3_FETCH_TIMEOUT_EN
            if (m_wait_n == TMO) begin m_err = 1; m_acc = 0; m_redir = 0; end
`endif
         end
      end else begin
         if (br_taken) m_pc = br_target;
         if (enable_fetch && !m_err) m_acc = 1;
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   always @(negedge clock) begin
      chk("cmp_rd",    {15'b0, instrmem_rd}, {15'b0, (m_acc == 1)});
      chk("cmp_macc",  {15'b0, I_macc},      {15'b0, (m_acc != 0)});
      chk("cmp_pc",    PC,        m_pc);
      chk("cmp_valid", {15'b0, instr_valid}, {15'b0, m_hold});
      chk("cmp_out",   instr_out, m_word);
      chk("cmp_ipc",   instr_pc,  m_wpc);
      chk("cmp_err",   {15'b0, fetch_err},   {15'b0, m_err});
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      model_reset();
      reset = 1'b0; enable_fetch = 1'b1; instr_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_pc", PC, 16'h3000);
      chk("rst_rd", {15'b0, instrmem_rd}, 16'h0);
      chk("rst_macc", {15'b0, I_macc}, 16'h0);
      chk("rst_valid", {15'b0, instr_valid}, 16'h0);
      chk("rst_out", instr_out, 16'h0000);
      chk("rst_ipc", instr_pc, 16'h0000);
      chk("rst_err", {15'b0, fetch_err}, 16'h0);
      tick(); reset = 1'b1;

      // first fetch: memory answers in the second WAIT cycle
      tick();
      @(negedge clock);
      chk("first_rd", {15'b0, instrmem_rd}, 16'h1);
      chk("first_req_pc", PC, 16'h3000);
      tick();
      tick();
      complete_instr = 1'b1; Instr_dout = 16'h1234;
      tick();
      complete_instr = 1'b0;
      @(negedge clock);
      chk("first_valid", {15'b0, instr_valid}, 16'h1);
      chk("first_out", instr_out, 16'h1234);
      chk("first_ipc", instr_pc, 16'h3000);
      chk("first_pc_inc", PC, 16'h3001);

      // back-pressure
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clock);
         chk("bp_valid", {15'b0, instr_valid}, 16'h1);
         chk("bp_out", instr_out, 16'h1234);
         chk("bp_ipc", instr_pc, 16'h3000);
         chk("bp_no_rd", {15'b0, instrmem_rd}, 16'h0);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      @(negedge clock);
      chk("acc_valid", {15'b0, instr_valid}, 16'h0);
      chk("acc_rd", {15'b0, instrmem_rd}, 16'h1);
      chk("acc_pc", PC, 16'h3001);

      // two redirects during WAIT, latest wins, data discarded
      tick();
      br_taken = 1'b1; br_target = 16'h4000;
      tick();
      br_target = 16'h5000;
      tick();
      br_taken = 1'b0; complete_instr = 1'b1; Instr_dout = 16'hBEEF;
      tick();
      complete_instr = 1'b0;
      @(negedge clock);
      chk("wredir_valid", {15'b0, instr_valid}, 16'h0);
      chk("wredir_rd", {15'b0, instrmem_rd}, 16'h1);
      chk("wredir_pc", PC, 16'h5000);

      // redirect in HOLD with instr_ready in the same cycle
      tick();
      complete_instr = 1'b1; Instr_dout = 16'h1111;
      tick();
      complete_instr = 1'b0;
      @(negedge clock);
      chk("hold_valid", {15'b0, instr_valid}, 16'h1);
      chk("hold_ipc", instr_pc, 16'h5000);
      br_taken = 1'b1; br_target = 16'hFFFF; instr_ready = 1'b1;
      tick();
      br_taken = 1'b0; instr_ready = 1'b0;
      @(negedge clock);
      chk("squash_valid", {15'b0, instr_valid}, 16'h0);
      chk("squash_pc", PC, 16'hFFFF);
      chk("squash_rd", {15'b0, instrmem_rd}, 16'h1);

      // wrap
      tick();
      complete_instr = 1'b1; Instr_dout = 16'h2222;
      tick();
      complete_instr = 1'b0;
      @(negedge clock);
      chk("wrap_ipc", instr_pc, 16'hFFFF);
      chk("wrap_out", instr_out, 16'h2222);
      chk("wrap_pc", PC, 16'h0000);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      @(negedge clock);
      chk("wrap_req_rd", {15'b0, instrmem_rd}, 16'h1);
      chk("wrap_req_pc", PC, 16'h0000);

`ifdef LC3_FETCH_TIMEOUT_EN
      // no completion: abort after TMO WAIT cycles
      repeat (TMO) tick();
      @(negedge clock);
      chk("tmo_pre_macc", {15'b0, I_macc}, 16'h1);
      chk("tmo_pre_err", {15'b0, fetch_err}, 16'h0);
      tick();
      @(negedge clock);
      chk("tmo_err", {15'b0, fetch_err}, 16'h1);
      chk("tmo_macc", {15'b0, I_macc}, 16'h0);
      chk("tmo_pc", PC, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clock);
         chk("tmo_no_rd", {15'b0, instrmem_rd}, 16'h0);
      end
`else
      // no completion: WAIT persists indefinitely
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clock);
         chk("wait_macc", {15'b0, I_macc}, 16'h1);
         chk("wait_err", {15'b0, fetch_err}, 16'h0);
      end
      complete_instr = 1'b1;
      tick();
      complete_instr = 1'b0;
`endif

      // reset, then randomized traffic with a latency-bounded memory responder
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      lat_left = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         enable_fetch = ($urandom_range(0, 9) < 8);
         br_taken     = ($urandom_range(0, 7) == 0);
         br_target    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         instr_ready  = ($urandom_range(0, 9) < 6);
         Instr_dout   = 16'($urandom);
         if (instrmem_rd) begin
            lat_left = $urandom_range(1, 3);
            complete_instr = ($urandom_range(0, 3) == 0);
         end else if (lat_left > 0) begin
            lat_left--;
            complete_instr = (lat_left == 0);
         end else begin
            complete_instr = ($urandom_range(0, 5) == 0);
         end
         reset = ($urandom_range(0, 249) != 0);
      end
      tick();
      reset = 1'b1; br_taken = 1'b0; complete_instr = 1'b0;
      @(negedge clock);
      #1;
      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end
endmodule
